serial_parity_rx: RTL and testbench
===================================

// Module: serial_parity_rx
// PURPOSE
//  Receiving end of the team's XOR-parity serial link. Deserialises one frame:
//  start(0), DATA_W data bits LSB-first, parity bit, stop(1).
//  Recomputes parity with a running XOR and flags parity and framing errors.
//  Sits between the link bit-sampler (which supplies bit_vld strobes) and the byte consumer.
// PARAMETERS
//  DATA_W      8  data bits per frame (legal range 1..32)
//  PARITY_ODD  0  0 = even parity (XOR of data ^ parity == 0); 1 = odd parity (== 1)
// PORTS
//  clk         in   1       rising-edge clock, sole clock
//  rst         in   1       asynchronous, active-high reset
//  bit_vld     in   1       bit_in is a sampled link bit this cycle
//  bit_in      in   1       serial data; idle level is 1
//  data_out    out  DATA_W  last received data word, held until the next frame completes
//  data_vld    out  1       1-cycle pulse: data_out updated (stop bit was good)
//  parity_err  out  1       1-cycle pulse coincident with data_vld: parity mismatch
//  frame_err   out  1       1-cycle pulse: stop bit sampled as 0
//  busy        out  1       high from start-bit acceptance until the frame ends
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, bit count=0, parity accumulator=0, data_out=0.
//   data_vld, parity_err, frame_err and busy are all 0.
//   A reset mid-frame abandons the frame with no pulse on any output.
//  State only advances on cycles with bit_vld=1; bit_vld=0 holds all state, with no timeout.
//  IDLE:   bit_vld & bit_in=0 -> DATA, busy=1, cnt=0, acc=PARITY_ODD.
//          bit_vld & bit_in=1 -> stay (idle line).
//  DATA:   each bit_vld: shift register[cnt]=bit_in, acc^=bit_in, cnt++.
//          When cnt reaches DATA_W-1 on a bit_vld -> PARITY.
//  PARITY: bit_vld: perr = acc ^ bit_in (1 = mismatch) -> STOP.
//  STOP:   bit_vld & bit_in=1: data_out<=shift register, data_vld=1, parity_err=perr.
//          bit_vld & bit_in=0: frame_err=1, data_out unchanged, data_vld=0, parity_err=0.
//          In both cases -> IDLE and busy=0.
//  Latency: all outputs are registered. Pulses appear in the cycle after the clk edge
//   that sampled the stop bit, i.e. 1 clk after stop-bit bit_vld. Each pulse is exactly 1 clk wide.
//  Back-to-back frames: a start bit on the first bit_vld after STOP is accepted.
//   A start bit may coincide with the data_vld pulse cycle.
//  Parity errors do not suppress data_vld; the consumer decides.
//   parity_err is never high without data_vld.
//  frame_err and data_vld are mutually exclusive.
//  Bit counter width is $clog2(DATA_W) (1 bit minimum). It never wraps within a frame.
// STRUCTURE
//  Shared package link_pkg:
//   - rx_state_t enum {IDLE, DATA, PARITY, STOP}
//   - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LVL=1'b1
//   The transmit side reuses these constants.
//  Sub-module parity_acc: clear/enable running XOR accumulator with a seed input.
//   Shared with the transmitter's parity generator.
//  The top level holds the FSM, bit counter, shift register and output registers.
// TESTING (DATA_W=8, PARITY_ODD=0 unless stated; bit_vld=1 every cycle unless stated)
//  1. Send 0xA5, parity 0, stop 1 -> data_out=0xA5, data_vld=1 for 1 clk, parity_err=0, frame_err=0.
//  2. Send 0x01 with parity 0 -> data_out=0x01, data_vld=1, parity_err=1.
//     Repeat with PARITY_ODD=1 and parity 0 -> parity_err=0.
//  3. Send 0x3C, parity 0, stop 0 -> frame_err=1 for 1 clk, data_vld=0, data_out keeps prior value.
//  4. Send 0x5A with bit_vld=0 for 3 clks between every bit -> same result as a gapless frame.
//     busy stays high throughout.
//  5. Assert rst after 4 data bits of 0xFF, release, then send 0x12 -> only one pulse (0x12).
//     All outputs 0 during reset.
//  6. Send frames 0x81 and 0x7E back-to-back with no idle bits -> two data_vld pulses.
//     Each shows its correct data and parity_err=0. Line held at 1 with bit_vld -> no activity.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the XOR-parity serial link: receiver state encoding
// and line-level constants used by both transmit and receive sides.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// Running XOR accumulator: clr loads the seed, en folds bit_in into the result.
// Also used by the transmitter's parity generator.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic seed,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= seed;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver for one XOR-parity frame: start(0), DATA_W data bits LSB-first,
// parity bit, stop(1). Reports the word plus parity and framing error pulses.
module serial_parity_rx
    import link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_vld,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              perr;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;

    assign acc_clr = (state == IDLE) && bit_vld && (bit_in == START_BIT);
    assign acc_en  = (state == DATA) && bit_vld;

    parity_acc u_parity_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .seed   (PARITY_ODD),
        .bit_in (bit_in),
        .acc    (acc)
    );

    // Shift register holds only payload; its contents are irrelevant until a full frame lands.
    always_ff @(posedge clk) begin
        if (acc_en) begin
            shreg[cnt] <= bit_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_vld) begin
                case (state)
                    IDLE: begin
                        if (bit_in == START_BIT) begin
                            state <= DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        // acc already carries the odd/even seed, so 1 means mismatch.
                        perr  <= acc ^ bit_in;
                        state <= STOP;
                    end
                    STOP: begin
                        if (bit_in == STOP_BIT) begin
                            data_out   <= shreg;
                            data_vld   <= 1'b1;
                            parity_err <= perr;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench: even- and odd-parity receivers share one serial stream;
// a frame-level model queues expected pulses, per-DUT monitors pop and compare.
module tb_serial_parity_rx;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_vld = 1'b0;
    logic       bit_in = 1'b1;

    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

    exp_t       q_e[$];
    exp_t       q_o[$];
    logic [7:0] last_e = 8'h00;
    logic [7:0] last_o = 8'h00;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .bit_vld(bit_vld), .bit_in(bit_in),
        .data_out(dout_e), .data_vld(dv_e), .parity_err(pe_e),
        .frame_err(fe_e), .busy(busy_e)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .bit_vld(bit_vld), .bit_in(bit_in),
        .data_out(dout_o), .data_vld(dv_o), .parity_err(pe_o),
        .frame_err(fe_o), .busy(busy_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic compare_pulse(input string tag, input logic dv, input logic pe,
                                 input logic fe, input logic [7:0] dout, input exp_t e);
        chk({tag, "_frame_err"}, fe, e.ferr);
        chk({tag, "_data_vld"}, dv, !e.ferr);
        chk({tag, "_parity_err"}, pe, e.perr);
        chk({tag, "_data_out"}, dout, e.data);
    endtask

    // Monitors: any pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (dv_e || fe_e) begin
                if (q_e.size() == 0) chk("even_unexpected_pulse", {dv_e, fe_e}, 0);
                else compare_pulse("even", dv_e, pe_e, fe_e, dout_e, q_e.pop_front());
            end
            if (pe_e && !dv_e) chk("even_perr_without_vld", 1, 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (dv_o || fe_o) begin
                if (q_o.size() == 0) chk("odd_unexpected_pulse", {dv_o, fe_o}, 0);
                else compare_pulse("odd", dv_o, pe_o, fe_o, dout_o, q_o.pop_front());
            end
            if (pe_o && !dv_o) chk("odd_perr_without_vld", 1, 0);
        end
    end

    // Frame-level reference: parity is checked from the XOR of all payload bits.
    task automatic expect_frame(input logic [7:0] d, input logic p, input logic stop);
        exp_t e;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        ones += p;
        e.ferr = !stop;
        e.data = stop ? d : last_e;
        e.perr = stop && ((ones % 2) != 0);
        q_e.push_back(e);
        if (stop) last_e = d;
        e.data = stop ? d : last_o;
        e.perr = stop && ((ones % 2) != 1);
        q_o.push_back(e);
        if (stop) last_o = d;
    endtask

    // Called at a falling edge; returns at the falling edge after gap idle cycles.
    task automatic send_bit(input logic b, input int gap);
        bit_vld = 1'b1;
        bit_in  = b;
        @(negedge clk);
        bit_vld = 1'b0;
        bit_in  = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int gap);
        expect_frame(d, p, stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        chk("busy_mid_frame", {busy_e, busy_o}, 2'b11);
        bit_vld = 1'b1;
        bit_in  = stop;
        @(negedge clk);
        chk("pulse_latency_even", dv_e | fe_e, 1);
        chk("pulse_latency_odd", dv_o | fe_o, 1);
        chk("busy_after_stop", {busy_e, busy_o}, 2'b00);
        bit_vld = 1'b0;
        bit_in  = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bit_vld = 1'b0;
        bit_in = 1'b1;
        @(negedge clk);
        chk("reset_outputs_even", {dout_e, dv_e, pe_e, fe_e, busy_e}, 0);
        chk("reset_outputs_odd", {dout_o, dv_o, pe_o, fe_o, busy_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        last_e = 8'h00;
        last_o = 8'h00;
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       stop;
        do_reset();

        send_frame(8'hA5, 1'b0, 1'b1, 0);
        send_frame(8'h01, 1'b0, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("frame_err_holds_data", dout_e, 8'h01);
        send_frame(8'h5A, 1'b0, 1'b1, 3);

        // Abandon a frame of 0xFF after four data bits.
        send_bit(1'b0, 0);
        repeat (4) send_bit(1'b1, 0);
        do_reset();
        send_frame(8'h12, 1'b0, 1'b1, 0);

        send_frame(8'h81, 1'b0, 1'b1, 0);
        send_frame(8'h7E, 1'b0, 1'b1, 0);
        repeat (20) send_bit(1'b1, 0);
        chk("idle_line_not_busy", {busy_e, busy_o}, 2'b00);

        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            p    = 1'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, p, stop, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) send_bit(1'b1, 0);
        end

        repeat (5) @(negedge clk);
        chk("even_queue_drained", q_e.size(), 0);
        chk("odd_queue_drained", q_o.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
